cam_ctrl: RTL and testbench
===========================

CAM_CTRL -- requirements
Module: cam_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have ports reqN_valid (N=0,1)  in  1 each  requester N command pending; held stable until reqN_ack.
REQ-004 SHALL have ports reqN_op  in  1 each  0=lookup, 1=replace.
REQ-005 SHALL have ports reqN_key, reqN_new  in  4 each  search value, replacement value.
REQ-006 SHALL have ports reqN_ack  out  1 each  one-cycle command-accepted strobe.
REQ-007 SHALL have port init_req  in  1  request CAM re-initialisation.
REQ-008 SHALL have ports rsp_valid/rsp_id/rsp_hit  out  1/1/1  response strobe, requester index, match flag.
REQ-009 SHALL have ports rsp_min, rsp_max  out  3 each  lowest/highest matching CAM address.
REQ-010 SHALL have ports cam_D_lookup, cam_newD  out  4 each; cam_setD, cam_init  out  1 each  CAM drive.
REQ-011 SHALL have ports cam_valid  in 1; cam_minAddr, cam_maxAddr  in 3 each  combinational CAM match results.
REQ-012 SHALL have ports busy  out 1 (state != IDLE) and hit_cnt  out 8 (saturating hit counter).

Function
REQ-013 FSM states SHALL be IDLE, LOOK, WRITE, RESP, INIT.
REQ-014 In IDLE, init_req SHALL have priority: next state INIT, no ack issued.
REQ-015 In IDLE without init_req, any reqN_valid SHALL be granted: reqN_ack=1 combinationally that cycle, command captured, next state LOOK.
REQ-016 Both valid SHALL be resolved round-robin: grant requester not granted last; last-grant pointer SHALL update on every grant.
REQ-017 LOOK: cam_D_lookup=captured key, cam_setD=0; cam_valid/minAddr/maxAddr SHALL be registered at end of cycle.
REQ-018 From LOOK: replace with cam_valid=1 -> WRITE; otherwise -> RESP.
REQ-019 WRITE: cam_D_lookup=key, cam_newD=new, cam_setD=1 for exactly one cycle; next RESP. key==new SHALL still write.
REQ-020 RESP: rsp_valid=1 for one cycle with rsp_id, rsp_hit and pre-write min/max; next IDLE; no grant in RESP.
REQ-021 On miss, rsp_min and rsp_max SHALL be 0 regardless of CAM outputs.
REQ-022 INIT: cam_init=1 for one cycle, next IDLE; no response generated.
REQ-023 Latency grant->rsp_valid: lookup 2 cycles, replace miss 2, replace hit 3.
REQ-024 hit_cnt SHALL increment on each RESP with rsp_hit=1, saturating at 255.
REQ-025 In IDLE/INIT/RESP, cam_setD=0; cam_D_lookup/cam_newD SHALL be 0 in IDLE and INIT.
REQ-026 Acks SHALL never both assert in the same cycle; at most one command in flight.

Reset
REQ-027 reset SHALL force state IDLE, last-grant pointer to 1 (req0 wins first tie), hit_cnt=0, captured regs=0.
REQ-028 During and the cycle after reset: rsp_valid=0, reqN_ack=0, cam_setD=0, cam_init=0, busy=0.
REQ-029 Reset mid-operation (LOOK/WRITE/RESP) SHALL abort silently: no rsp_valid, no further cam_setD.

Verification
REQ-030 init_req pulse, CAM init pattern r0..r7=8,9,A,B,C,D,E,F; req0 lookup key=A -> ack0 cycle 0, rsp_valid cycle 2, rsp_id=0, hit=1, min=2, max=2, hit_cnt=1.
REQ-031 req1 replace key=C new=9 -> cam_setD=1 only in cycle 2, rsp cycle 3 hit=1 min=4 max=4; then lookup 9 -> hit=1 min=1 max=4.
REQ-032 req0 lookup key=3 (no match) -> rsp cycle 2 hit=0 min=0 max=0, hit_cnt unchanged, no WRITE state.
REQ-033 req0 and req1 valid same cycle after reset -> ack0 first, ack1 after RESP; repeated ties alternate 0,1,0,1.
REQ-034 reset asserted during WRITE -> next cycle cam_setD=0, busy=0, no rsp_valid; init_req and req0 simultaneous in IDLE -> INIT first, ack0 only after return to IDLE.
REQ-035 256+ hitting lookups -> hit_cnt holds 255.

Source files
------------

// File: rtl/cam_ctrl_if.sv
// Bundle of requester, response, CAM-drive and status signals for cam_ctrl.
interface cam_ctrl_if;
   localparam int unsigned KEY_W  = 4;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned CNT_W  = 8;

   logic              req0_valid;
   logic              req0_op;
   logic [KEY_W-1:0]  req0_key;
   logic [KEY_W-1:0]  req0_new;
   logic              req0_ack;
   logic              req1_valid;
   logic              req1_op;
   logic [KEY_W-1:0]  req1_key;
   logic [KEY_W-1:0]  req1_new;
   logic              req1_ack;
   logic              init_req;
   logic              rsp_valid;
   logic              rsp_id;
   logic              rsp_hit;
   logic [ADDR_W-1:0] rsp_min;
   logic [ADDR_W-1:0] rsp_max;
   logic [KEY_W-1:0]  cam_D_lookup;
   logic [KEY_W-1:0]  cam_newD;
   logic              cam_setD;
   logic              cam_init;
   logic              cam_valid;
   logic [ADDR_W-1:0] cam_minAddr;
   logic [ADDR_W-1:0] cam_maxAddr;
   logic              busy;
   logic [CNT_W-1:0]  hit_cnt;

   // Environment side: requesters plus the CAM array itself.
   modport master (
      output req0_valid, req0_op, req0_key, req0_new,
      output req1_valid, req1_op, req1_key, req1_new,
      output init_req, cam_valid, cam_minAddr, cam_maxAddr,
      input  req0_ack, req1_ack, rsp_valid, rsp_id, rsp_hit, rsp_min, rsp_max,
      input  cam_D_lookup, cam_newD, cam_setD, cam_init, busy, hit_cnt
   );

   // Controller side.
   modport slave (
      input  req0_valid, req0_op, req0_key, req0_new,
      input  req1_valid, req1_op, req1_key, req1_new,
      input  init_req, cam_valid, cam_minAddr, cam_maxAddr,
      output req0_ack, req1_ack, rsp_valid, rsp_id, rsp_hit, rsp_min, rsp_max,
      output cam_D_lookup, cam_newD, cam_setD, cam_init, busy, hit_cnt
   );
endinterface

// File: rtl/cam_ctrl.sv
// Two-requester CAM command controller: round-robin grant, lookup,
// optional replace write, single response, and CAM re-initialisation.
module cam_ctrl (
   input logic       clk,
   input logic       reset,
   cam_ctrl_if.slave bus
);
   localparam int unsigned KEY_W  = 4;
   localparam int unsigned ADDR_W = 3;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [2:0] {IDLE, LOOK, WRITE, RESP, INIT} state_t;

   state_t            state;
   logic              last_grant;
   logic              rst_hold;
   logic              cap_id;
   logic              cap_op;
   logic              cap_hit;
   logic [KEY_W-1:0]  cap_key;
   logic [KEY_W-1:0]  cap_new;
   logic [ADDR_W-1:0] cap_min;
   logic [ADDR_W-1:0] cap_max;
   logic [CNT_W-1:0]  hit_cnt;
   logic              rsp_valid;
   logic              rsp_id;
   logic              rsp_hit;
   logic [ADDR_W-1:0] rsp_min;
   logic [ADDR_W-1:0] rsp_max;
   logic [KEY_W-1:0]  cam_d_lookup;
   logic [KEY_W-1:0]  cam_new_d;
   logic              cam_set_d;
   logic              cam_init;
   logic              busy;
   logic              can_grant;
   logic              grant0;
   logic              grant1;

   // Grant decode; acks are same-cycle strobes and are mutually exclusive.
   always_comb begin
      can_grant = (state == IDLE) && !reset && !rst_hold && !bus.init_req;
      grant0    = can_grant && bus.req0_valid && (!bus.req1_valid || last_grant);
      grant1    = can_grant && bus.req1_valid && (!bus.req0_valid || !last_grant);
   end

   // Controller FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         rst_hold     <= 1'b1;
         cap_id       <= 1'b0;
         cap_op       <= 1'b0;
         cap_hit      <= 1'b0;
         cap_key      <= '0;
         cap_new      <= '0;
         cap_min      <= '0;
         cap_max      <= '0;
         hit_cnt      <= '0;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_hit      <= 1'b0;
         rsp_min      <= '0;
         rsp_max      <= '0;
         cam_d_lookup <= '0;
         cam_new_d    <= '0;
         cam_set_d    <= 1'b0;
         cam_init     <= 1'b0;
         busy         <= 1'b0;
      end else begin
         rst_hold  <= 1'b0;
         rsp_valid <= 1'b0;
         cam_set_d <= 1'b0;
         cam_init  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!rst_hold && bus.init_req) begin
                  state    <= INIT;
                  cam_init <= 1'b1;
                  busy     <= 1'b1;
               end else if (grant0 || grant1) begin
                  state        <= LOOK;
                  busy         <= 1'b1;
                  last_grant   <= grant1;
                  cap_id       <= grant1;
                  cap_op       <= grant1 ? bus.req1_op  : bus.req0_op;
                  cap_key      <= grant1 ? bus.req1_key : bus.req0_key;
                  cap_new      <= grant1 ? bus.req1_new : bus.req0_new;
                  cam_d_lookup <= grant1 ? bus.req1_key : bus.req0_key;
                  cam_new_d    <= '0;
               end
            end
            LOOK: begin
               // Match results are captured before any write disturbs them.
               cap_hit <= bus.cam_valid;
               cap_min <= bus.cam_valid ? bus.cam_minAddr : '0;
               cap_max <= bus.cam_valid ? bus.cam_maxAddr : '0;
               if (cap_op && bus.cam_valid) begin
                  state        <= WRITE;
                  cam_set_d    <= 1'b1;
                  cam_d_lookup <= cap_key;
                  cam_new_d    <= cap_new;
               end else begin
                  state        <= RESP;
                  rsp_valid    <= 1'b1;
                  rsp_id       <= cap_id;
                  rsp_hit      <= bus.cam_valid;
                  rsp_min      <= bus.cam_valid ? bus.cam_minAddr : '0;
                  rsp_max      <= bus.cam_valid ? bus.cam_maxAddr : '0;
                  cam_d_lookup <= '0;
                  cam_new_d    <= '0;
               end
            end
            WRITE: begin
               state        <= RESP;
               rsp_valid    <= 1'b1;
               rsp_id       <= cap_id;
               rsp_hit      <= cap_hit;
               rsp_min      <= cap_min;
               rsp_max      <= cap_max;
               cam_d_lookup <= '0;
               cam_new_d    <= '0;
            end
            RESP: begin
               state <= IDLE;
               busy  <= 1'b0;
               if (rsp_hit && (hit_cnt != '1)) hit_cnt <= hit_cnt + CNT_W'(1);
            end
            INIT: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.req0_ack     = grant0;
   assign bus.req1_ack     = grant1;
   assign bus.rsp_valid    = rsp_valid;
   assign bus.rsp_id       = rsp_id;
   assign bus.rsp_hit      = rsp_hit;
   assign bus.rsp_min      = rsp_min;
   assign bus.rsp_max      = rsp_max;
   assign bus.cam_D_lookup = cam_d_lookup;
   assign bus.cam_newD     = cam_new_d;
   assign bus.cam_setD     = cam_set_d;
   assign bus.cam_init     = cam_init;
   assign bus.busy         = busy;
   assign bus.hit_cnt      = hit_cnt;
endmodule

// File: tb/tb_cam_ctrl.sv
// Directed bench for cam_ctrl with a behavioural 8x4 CAM model.
module tb_cam_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   cam_ctrl_if bus ();
   cam_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_bad = 0;
   int exp_cnt = 0;

   // CAM array: init loads 8..F, setD replaces every matching entry.
   logic [3:0] mem [8];
   always @(posedge clk) begin
      if (bus.cam_init) begin
         for (int i = 0; i < 8; i++) mem[i] <= 4'(8 + i);
      end else if (bus.cam_setD) begin
         for (int i = 0; i < 8; i++) if (mem[i] == bus.cam_D_lookup) mem[i] <= bus.cam_newD;
      end
   end

   // Match outputs; on a miss min/max carry junk the controller must mask.
   always_comb begin
      bus.cam_valid   = 1'b0;
      bus.cam_minAddr = 3'd7;
      bus.cam_maxAddr = 3'd5;
      for (int i = 7; i >= 0; i--) begin
         if (mem[i] == bus.cam_D_lookup) begin
            if (!bus.cam_valid) bus.cam_maxAddr = 3'(i);
            bus.cam_minAddr = 3'(i);
            bus.cam_valid   = 1'b1;
         end
      end
   end

   typedef struct {
      logic       id;
      logic       op;
      logic [3:0] key;
      logic [3:0] nw;
      logic       hit;
      logic [2:0] mn;
      logic [2:0] mx;
      int         lat;
   } vec_t;

   vec_t vecs [11];

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic id, input logic op, input logic [3:0] key,
                            input logic [3:0] nw, input logic vld);
      if (id) begin
         bus.req1_op = op; bus.req1_key = key; bus.req1_new = nw; bus.req1_valid = vld;
      end else begin
         bus.req0_op = op; bus.req0_key = key; bus.req0_new = nw; bus.req0_valid = vld;
      end
   endtask

   task automatic do_cmd(input vec_t v, input int idx);
      int n;
      int lat;
      int nset;
      int setcyc;
      @(negedge clk);
      drive_req(v.id, v.op, v.key, v.nw, 1'b1);
      #1;
      n = 0;
      while (!(v.id ? bus.req1_ack : bus.req0_ack) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk($sformatf("v%0d ack", idx), int'(v.id ? bus.req1_ack : bus.req0_ack), 1);
      chk($sformatf("v%0d other_ack", idx), int'(v.id ? bus.req0_ack : bus.req1_ack), 0);
      @(posedge clk); #1;
      drive_req(v.id, 1'b0, 4'h0, 4'h0, 1'b0);
      lat = 1; nset = 0; setcyc = 0;
      while (!bus.rsp_valid && lat < 10) begin
         if (bus.cam_setD) begin nset++; setcyc = lat; end
         @(posedge clk); #1; lat++;
      end
      chk($sformatf("v%0d latency", idx), lat, v.lat);
      chk($sformatf("v%0d rsp_id", idx), int'(bus.rsp_id), int'(v.id));
      chk($sformatf("v%0d rsp_hit", idx), int'(bus.rsp_hit), int'(v.hit));
      chk($sformatf("v%0d rsp_min", idx), int'(bus.rsp_min), int'(v.mn));
      chk($sformatf("v%0d rsp_max", idx), int'(bus.rsp_max), int'(v.mx));
      chk($sformatf("v%0d setD_count", idx), nset, (v.op && v.hit) ? 1 : 0);
      chk($sformatf("v%0d setD_cycle", idx), setcyc, (v.op && v.hit) ? 2 : 0);
      if (v.hit) exp_cnt++;
      @(posedge clk); #1;
      chk($sformatf("v%0d rsp_one_cycle", idx), int'(bus.rsp_valid), 0);
      chk($sformatf("v%0d hit_cnt", idx), int'(bus.hit_cnt), exp_cnt);
      chk($sformatf("v%0d busy_after", idx), int'(bus.busy), 0);
   endtask

   task automatic reset_dut();
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      exp_cnt = 0;
   endtask

   task automatic init_pulse();
      @(negedge clk);
      bus.init_req = 1'b1;
      @(posedge clk); #1;
      bus.init_req = 1'b0;
      chk("init cam_init", int'(bus.cam_init), 1);
      chk("init busy", int'(bus.busy), 1);
      @(posedge clk); #1;
      chk("init cam_init_one_cycle", int'(bus.cam_init), 0);
      chk("init no_rsp", int'(bus.rsp_valid), 0);
      chk("init busy_after", int'(bus.busy), 0);
   endtask

   initial begin
      int n;
      int nr;
      int gnt;
      bus.req0_valid = 0; bus.req0_op = 0; bus.req0_key = 0; bus.req0_new = 0;
      bus.req1_valid = 0; bus.req1_op = 0; bus.req1_key = 0; bus.req1_new = 0;
      bus.init_req = 0;

      // id, op, key, new, hit, min, max, latency
      vecs[0]  = '{1'b0, 1'b0, 4'hA, 4'h0, 1'b1, 3'd2, 3'd2, 2};
      vecs[1]  = '{1'b1, 1'b1, 4'hC, 4'h9, 1'b1, 3'd4, 3'd4, 3};
      vecs[2]  = '{1'b0, 1'b0, 4'h9, 4'h0, 1'b1, 3'd1, 3'd4, 2};
      vecs[3]  = '{1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 3'd0, 3'd0, 2};
      vecs[4]  = '{1'b1, 1'b1, 4'h3, 4'h5, 1'b0, 3'd0, 3'd0, 2};
      vecs[5]  = '{1'b0, 1'b1, 4'h9, 4'h9, 1'b1, 3'd1, 3'd4, 3};
      vecs[6]  = '{1'b1, 1'b1, 4'h9, 4'h2, 1'b1, 3'd1, 3'd4, 3};
      vecs[7]  = '{1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 3'd7, 3'd7, 2};
      vecs[8]  = '{1'b1, 1'b0, 4'h8, 4'h0, 1'b1, 3'd0, 3'd0, 2};
      vecs[9]  = '{1'b0, 1'b0, 4'h9, 4'h0, 1'b0, 3'd0, 3'd0, 2};
      vecs[10] = '{1'b1, 1'b0, 4'h2, 4'h0, 1'b1, 3'd1, 3'd4, 2};

      // Reset behaviour with a request already pending.
      @(negedge clk);
      reset = 1'b1;
      bus.req0_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst ack0", int'(bus.req0_ack), 0);
      chk("rst rsp_valid", int'(bus.rsp_valid), 0);
      chk("rst setD", int'(bus.cam_setD), 0);
      chk("rst cam_init", int'(bus.cam_init), 0);
      chk("rst busy", int'(bus.busy), 0);
      chk("rst hit_cnt", int'(bus.hit_cnt), 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("post_rst ack0", int'(bus.req0_ack), 0);
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      chk("post_rst busy", int'(bus.busy), 0);
      chk("post_rst rsp_valid", int'(bus.rsp_valid), 0);

      init_pulse();

      foreach (vecs[i]) do_cmd(vecs[i], i);

      // Simultaneous requests resolve 0,1,0,1 starting from reset.
      reset_dut();
      @(negedge clk);
      drive_req(1'b0, 1'b0, 4'h8, 4'h0, 1'b1);
      drive_req(1'b1, 1'b0, 4'h8, 4'h0, 1'b1);
      for (int g = 0; g < 4; g++) begin
         #1;
         n = 0;
         while (!(bus.req0_ack || bus.req1_ack) && n < 20) begin
            @(negedge clk); #1; n++;
         end
         chk($sformatf("tie%0d any_ack", g), int'(bus.req0_ack || bus.req1_ack), 1);
         chk($sformatf("tie%0d both_ack", g), int'(bus.req0_ack && bus.req1_ack), 0);
         chk($sformatf("tie%0d winner", g), int'(bus.req1_ack), g % 2);
         gnt = int'(bus.req1_ack);
         @(posedge clk); #1;
         drive_req(1'(gnt), 1'b0, 4'h8, 4'h0, 1'b0);
         if (g < 3) begin
            @(negedge clk);
            drive_req(1'(gnt), 1'b0, 4'h8, 4'h0, 1'b1);
         end
      end
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      drive_req(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
      repeat (4) @(posedge clk);

      // Reset landing in WRITE aborts the command silently.
      @(negedge clk);
      drive_req(1'b0, 1'b1, 4'hA, 4'hA, 1'b1);
      #1;
      n = 0;
      while (!bus.req0_ack && n < 20) begin @(negedge clk); #1; n++; end
      chk("abort ack0", int'(bus.req0_ack), 1);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      @(posedge clk); #1;
      chk("abort in_write setD", int'(bus.cam_setD), 1);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("abort setD", int'(bus.cam_setD), 0);
      chk("abort busy", int'(bus.busy), 0);
      chk("abort rsp_valid", int'(bus.rsp_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      nr = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.rsp_valid || bus.cam_setD) nr++;
      end
      chk("abort silent", nr, 0);

      // init_req beats a simultaneous request; the request waits for IDLE.
      @(negedge clk);
      bus.init_req = 1'b1;
      drive_req(1'b0, 1'b0, 4'hB, 4'h0, 1'b1);
      #1;
      chk("initpri ack0_idle", int'(bus.req0_ack), 0);
      @(posedge clk); #1;
      bus.init_req = 1'b0;
      chk("initpri cam_init", int'(bus.cam_init), 1);
      chk("initpri ack0_init", int'(bus.req0_ack), 0);
      @(posedge clk); #1;
      chk("initpri cam_init_off", int'(bus.cam_init), 0);
      chk("initpri ack0_after", int'(bus.req0_ack), 1);
      @(posedge clk); #1;
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      n = 0;
      while (!bus.rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
      chk("initpri rsp_hit", int'(bus.rsp_hit), 1);
      chk("initpri rsp_min", int'(bus.rsp_min), 3);
      chk("initpri rsp_max", int'(bus.rsp_max), 3);

      // Hit counter saturation.
      reset_dut();
      init_pulse();
      @(negedge clk);
      drive_req(1'b0, 1'b0, 4'h8, 4'h0, 1'b1);
      nr = 0;
      n = 0;
      while (nr < 260 && n < 1500) begin
         @(posedge clk); #1; n++;
         if (bus.rsp_valid && bus.rsp_hit) nr++;
      end
      drive_req(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk("sat responses", int'(nr >= 260), 1);
      chk("sat hit_cnt", int'(bus.hit_cnt), 255);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
